// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared constants and types for the ROM/RAM bus arbiter.
//   - Memory map bases and region size (ROM at 0x000, RAM at 0x800, 2 KiB each).
//   - FSM state, region-select and requester-port enumerations.
//   - in_region(): byte-address range test against a region base.
package mem_bus_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned IdxW  = 9;

  localparam logic [AddrW-1:0] RomBase       = 32'h0000_0000;
  localparam logic [AddrW-1:0] RamBase       = 32'h0000_0800;
  localparam logic [AddrW-1:0] MemRegionSize = 32'h0000_0800;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RegNone = 2'd0,
    RegRom  = 2'd1,
    RegRam  = 2'd2
  } region_e;

  typedef enum logic {
    PortIf = 1'b0,
    PortDm = 1'b1
  } port_e;

  function automatic logic in_region(input logic [AddrW-1:0] addr,
                                     input logic [AddrW-1:0] base);
    return (addr >= base) && ((addr - base) < MemRegionSize);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the two requester ports (IF fetch, DM load/store) and the
// ROM / data-RAM strobe buses seen by the arbiter.
//   slave  : arbiter view (requests and memory read buses in; acks, rdata, strobes out).
//   master : environment view (requesters and memories), the mirror image.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // Instruction-fetch port
  logic             if_req;
  logic [AddrW-1:0] if_addr;
  logic             if_ack;
  logic [DataW-1:0] if_rdata;
  // Load/store port
  logic             dm_req;
  logic             dm_we;
  logic [AddrW-1:0] dm_addr;
  logic [DataW-1:0] dm_wdata;
  logic             dm_ack;
  logic [DataW-1:0] dm_rdata;
  logic             dm_err;
  // ROM
  logic             rom_nce;
  logic             rom_re;
  logic [IdxW-1:0]  rom_addr;
  logic [DataW-1:0] rom_data;
  // Data RAM
  logic             ram_nce;
  logic             ram_re;
  logic             ram_we;
  logic [IdxW-1:0]  ram_addr;
  logic [DataW-1:0] ram_wdata;
  logic [DataW-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, rom_data, ram_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, dm_err,
    output rom_nce, rom_re, rom_addr, ram_nce, ram_re, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, rom_data, ram_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, dm_err,
    input  rom_nce, rom_re, rom_addr, ram_nce, ram_re, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: combinational byte-address decoder for the arbiter.
//   addr_i   : byte address of the granted request
//   we_i     : 1 = store
//   region_o : RegRom / RegRam / RegNone
//   idx_o    : 9-bit word index (addr[10:2]) within the region
//   err_o    : unmapped, misaligned, or store to ROM
module mem_addr_decode
  import mem_bus_arbiter_pkg::*;
(
  input  logic [AddrW-1:0] addr_i,
  input  logic             we_i,
  output region_e          region_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             err_o
);

  always_comb begin
    region_o = RegNone;
    if (in_region(addr_i, RomBase)) begin
      region_o = RegRom;
    end else if (in_region(addr_i, RamBase)) begin
      region_o = RegRam;
    end
  end

  assign idx_o = addr_i[IdxW+1:2];
  assign err_o = (region_o == RegNone) || (addr_i[1:0] != 2'b00) ||
                 ((region_o == RegRom) && we_i);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the instruction ROM and data RAM between the IF and DM ports.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   bus_io  : mem_bus_arbiter_if.slave (requests/acks/rdata and ROM/RAM strobes)
// FSM IDLE -> ACCESS (WAIT_STATES+1 strobe cycles) -> RESP (one-cycle ack) -> IDLE;
// decode errors skip ACCESS. All outputs are registered.
// Build option: MEM_BUS_ARB_RR_EN selects round-robin on a tie; otherwise DM wins ties.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus_io
);

  localparam logic [2:0] WaitLast = 3'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  port_e            win_q, win_d;
  region_e          region_q, region_d;
  logic             rom_nce_q, rom_nce_d;
  logic             rom_re_q, rom_re_d;
  logic [IdxW-1:0]  rom_addr_q, rom_addr_d;
  logic             ram_nce_q, ram_nce_d;
  logic             ram_re_q, ram_re_d;
  logic             ram_we_q, ram_we_d;
  logic [IdxW-1:0]  ram_addr_q, ram_addr_d;
  logic [DataW-1:0] ram_wdata_q, ram_wdata_d;
  logic             if_ack_q, if_ack_d;
  logic             dm_ack_q, dm_ack_d;
  logic             dm_err_q, dm_err_d;
  logic [DataW-1:0] if_rdata_q, if_rdata_d;
  logic [DataW-1:0] dm_rdata_q, dm_rdata_d;

  logic             any_req;
  port_e            grant;
  port_e            tie_winner;
  logic [AddrW-1:0] req_addr;
  logic             req_we;
  region_e          dec_region;
  logic [IdxW-1:0]  dec_idx;
  logic             dec_err;
  logic [DataW-1:0] mem_rdata;

`ifdef MEM_BUS_ARB_RR_EN
  port_e last_q;

  // Last-grant tracks every grant, including errored ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PortDm;
    end else if (state_q == StIdle && any_req) begin
      last_q <= grant;
    end
  end

  assign tie_winner = (last_q == PortDm) ? PortIf : PortDm;
`else
  assign tie_winner = PortDm;
`endif

  assign any_req = bus_io.if_req | bus_io.dm_req;

  always_comb begin
    grant = PortDm;
    if (bus_io.if_req && !bus_io.dm_req) begin
      grant = PortIf;
    end else if (bus_io.if_req && bus_io.dm_req) begin
      grant = tie_winner;
    end
  end

  assign req_addr = (grant == PortDm) ? bus_io.dm_addr : bus_io.if_addr;
  assign req_we   = (grant == PortDm) & bus_io.dm_we;

  mem_addr_decode u_decode (
    .addr_i   (req_addr),
    .we_i     (req_we),
    .region_o (dec_region),
    .idx_o    (dec_idx),
    .err_o    (dec_err)
  );

  assign mem_rdata = (region_q == RegRom) ? bus_io.rom_data : bus_io.ram_rdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    region_d    = region_q;
    rom_nce_d   = rom_nce_q;
    rom_re_d    = rom_re_q;
    rom_addr_d  = rom_addr_q;
    ram_nce_d   = ram_nce_q;
    ram_re_d    = ram_re_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d    = grant;
          region_d = dec_region;
          if (dec_err) begin
            // No strobes: answer straight away with zero data.
            state_d = StResp;
            if (grant == PortDm) begin
              dm_ack_d   = 1'b1;
              dm_err_d   = 1'b1;
              dm_rdata_d = '0;
            end else begin
              if_ack_d   = 1'b1;
              if_rdata_d = '0;
            end
          end else begin
            state_d = StAccess;
            cnt_d   = 3'd0;
            if (dec_region == RegRom) begin
              rom_nce_d  = 1'b0;
              rom_re_d   = 1'b1;
              rom_addr_d = dec_idx;
            end else begin
              ram_nce_d   = 1'b0;
              ram_re_d    = ~req_we;
              ram_we_d    = req_we;
              ram_addr_d  = dec_idx;
              ram_wdata_d = bus_io.dm_wdata;
            end
          end
        end
      end

      StAccess: begin
        if (cnt_q == WaitLast) begin
          state_d   = StResp;
          rom_nce_d = 1'b1;
          rom_re_d  = 1'b0;
          ram_nce_d = 1'b1;
          ram_re_d  = 1'b0;
          ram_we_d  = 1'b0;
          if (win_q == PortDm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      win_q       <= PortDm;
      region_q    <= RegNone;
      rom_nce_q   <= 1'b1;
      rom_re_q    <= 1'b0;
      rom_addr_q  <= '0;
      ram_nce_q   <= 1'b1;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      region_q    <= region_d;
      rom_nce_q   <= rom_nce_d;
      rom_re_q    <= rom_re_d;
      rom_addr_q  <= rom_addr_d;
      ram_nce_q   <= ram_nce_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus_io.rom_nce   = rom_nce_q;
  assign bus_io.rom_re    = rom_re_q;
  assign bus_io.rom_addr  = rom_addr_q;
  assign bus_io.ram_nce   = ram_nce_q;
  assign bus_io.ram_re    = ram_re_q;
  assign bus_io.ram_we    = ram_we_q;
  assign bus_io.ram_addr  = ram_addr_q;
  assign bus_io.ram_wdata = ram_wdata_q;
  assign bus_io.if_ack    = if_ack_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.dm_ack    = dm_ack_q;
  assign bus_io.dm_rdata  = dm_rdata_q;
  assign bus_io.dm_err    = dm_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter.
// Main instance uses WAIT_STATES=1 with ROM/RAM models; two extra instances (0 and 7 wait
// states) check strobe width and ack latency. Latency counts the request cycle as cycle 1.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter_if bus1 ();
  mem_bus_arbiter_if bus0 ();
  mem_bus_arbiter_if bus7 ();

  mem_bus_arbiter #(.WAIT_STATES(1)) u_dut  (.clk(clk), .rst(rst), .bus_io(bus1));
  mem_bus_arbiter #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus_io(bus0));
  mem_bus_arbiter #(.WAIT_STATES(7)) u_dut7 (.clk(clk), .rst(rst), .bus_io(bus7));

  logic [31:0] rom_mem [512];
  logic [31:0] ram_mem [512];
  logic [31:0] ref_ram [512];

  assign bus1.rom_data  = rom_mem[bus1.rom_addr];
  assign bus1.ram_rdata = ram_mem[bus1.ram_addr];
  assign bus0.rom_data  = 32'hA5A5_0000 | {23'd0, bus0.rom_addr};
  assign bus0.ram_rdata = 32'h0;
  assign bus7.rom_data  = 32'hA5A5_0000 | {23'd0, bus7.rom_addr};
  assign bus7.ram_rdata = 32'h0;

  // Synchronous RAM device model.
  initial begin
    for (int i = 0; i < 512; i++) ram_mem[i] = 32'hC0DE_0000 | i;
    forever begin
      @(posedge clk);
      if (!bus1.ram_nce && bus1.ram_we) ram_mem[bus1.ram_addr] = bus1.ram_wdata;
    end
  end

  task automatic idle_inputs();
    bus1.if_req = 0; bus1.if_addr = 0; bus1.dm_req = 0; bus1.dm_we = 0;
    bus1.dm_addr = 0; bus1.dm_wdata = 0;
    bus0.if_req = 0; bus0.if_addr = 0; bus0.dm_req = 0; bus0.dm_we = 0;
    bus0.dm_addr = 0; bus0.dm_wdata = 0;
    bus7.if_req = 0; bus7.if_addr = 0; bus7.dm_req = 0; bus7.dm_we = 0;
    bus7.dm_addr = 0; bus7.dm_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One transaction on the main instance, checked against the memory-map rules.
  task automatic do_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int region, exp_lat, exp_good, good, bad, lat;
    bit exp_err, seen, ok, act;
    logic [8:0] idx;
    logic [31:0] exp_rd;
    if (!is_dm) we = 1'b0;
    region  = (addr < 32'h800) ? 1 : (addr < 32'h1000) ? 2 : 0;
    exp_err = (region == 0) || (addr % 4 != 0) || (region == 1 && we);
    idx     = 9'((addr % 2048) / 4);
    exp_rd  = 32'h0;
    if (!exp_err && region == 1) exp_rd = rom_mem[idx];
    if (!exp_err && region == 2 && !we) exp_rd = ref_ram[idx];
    exp_lat  = exp_err ? 2 : 4;
    exp_good = exp_err ? 0 : 2;
    if (is_dm) begin
      bus1.dm_req = 1; bus1.dm_we = we; bus1.dm_addr = addr; bus1.dm_wdata = wdata;
    end else begin
      bus1.if_req = 1; bus1.if_addr = addr;
    end
    good = 0; bad = 0; lat = 1; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      lat++;
      act = !bus1.rom_nce || bus1.rom_re || !bus1.ram_nce || bus1.ram_re || bus1.ram_we;
      ok = 0;
      if (!exp_err && region == 1)
        ok = !bus1.rom_nce && bus1.rom_re && bus1.rom_addr == idx && bus1.ram_nce &&
             !bus1.ram_re && !bus1.ram_we;
      else if (!exp_err && region == 2)
        ok = !bus1.ram_nce && bus1.rom_nce && !bus1.rom_re && bus1.ram_addr == idx &&
             (we ? (bus1.ram_we && !bus1.ram_re && bus1.ram_wdata == wdata)
                 : (bus1.ram_re && !bus1.ram_we));
      if (ok) good++;
      else if (act) bad++;
      if (bus1.if_ack || bus1.dm_ack) begin
        seen = 1;
        checks++;
        if (lat !== exp_lat) begin
          errors++; $display("FAIL latency addr=%h: got %0d want %0d", addr, lat, exp_lat);
        end
        checks++;
        if ({bus1.dm_ack, bus1.if_ack} !== (is_dm ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL ack_port addr=%h: got dm/if=%b%b want dm=%0b", addr,
                   bus1.dm_ack, bus1.if_ack, is_dm);
        end
        if (!(is_dm && we && !exp_err)) begin
          checks++;
          if ((is_dm ? bus1.dm_rdata : bus1.if_rdata) !== exp_rd) begin
            errors++;
            $display("FAIL rdata addr=%h: got %h want %h", addr,
                     is_dm ? bus1.dm_rdata : bus1.if_rdata, exp_rd);
          end
        end
        if (is_dm) begin
          checks++;
          if (bus1.dm_err !== exp_err) begin
            errors++; $display("FAIL dm_err addr=%h: got %b want %b", addr, bus1.dm_err, exp_err);
          end
        end
        bus1.if_req = 0; bus1.dm_req = 0;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ack_timeout addr=%h: got no ack want ack", addr);
      bus1.if_req = 0; bus1.dm_req = 0;
    end
    checks++;
    if (good !== exp_good || bad !== 0) begin
      errors++;
      $display("FAIL strobes addr=%h: got good=%0d bad=%0d want good=%0d bad=0", addr, good,
               bad, exp_good);
    end
    if (is_dm && we && !exp_err) ref_ram[idx] = wdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus1.rom_nce, bus1.ram_nce, bus1.rom_re, bus1.ram_re, bus1.ram_we, bus1.if_ack,
         bus1.dm_ack, bus1.dm_err} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 11000000", {bus1.rom_nce, bus1.ram_nce,
               bus1.rom_re, bus1.ram_re, bus1.ram_we, bus1.if_ack, bus1.dm_ack, bus1.dm_err});
    end
    checks++;
    if ({bus1.rom_addr, bus1.ram_addr, bus1.ram_wdata} !== 50'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 0", {bus1.rom_addr, bus1.ram_addr, bus1.ram_wdata});
    end
    checks++;
    if ({bus1.if_rdata, bus1.dm_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", {bus1.if_rdata, bus1.dm_rdata});
    end
    checks++;
    if ({bus0.rom_nce, bus0.ram_nce, bus7.rom_nce, bus7.ram_nce} !== 4'hF) begin
      errors++;
      $display("FAIL reset_nce_ws: got %b want 1111", {bus0.rom_nce, bus0.ram_nce,
               bus7.rom_nce, bus7.ram_nce});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus1.rom_nce, bus1.ram_nce, bus1.if_ack, bus1.dm_ack} !== 4'b1100) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 1100", {bus1.rom_nce, bus1.ram_nce,
               bus1.if_ack, bus1.dm_ack});
    end
  endtask

  task automatic test_directed();
    do_txn(0, 0, 32'h0000_0004, 32'h0);          // ROM fetch, word 0x0001_0A00
    do_txn(1, 1, 32'h0000_0810, 32'hDEAD_BEEF);  // RAM store
    do_txn(1, 0, 32'h0000_0810, 32'h0);          // read it back
    do_txn(1, 1, 32'h0000_0010, 32'h1111_1111);  // store to ROM
    do_txn(1, 0, 32'h0000_2000, 32'h0);          // unmapped load
    do_txn(1, 0, 32'h0000_0802, 32'h0);          // misaligned
    do_txn(0, 0, 32'h0000_0FFC, 32'h0);          // IF read of RAM top word
    do_txn(0, 0, 32'hFFFF_F000, 32'h0);          // IF unmapped
  endtask

  task automatic test_rdata_hold();
    do_txn(0, 0, 32'h0000_0014, 32'h0);
    do_txn(1, 0, 32'h0000_0900, 32'h0);
    checks++;
    if (bus1.if_rdata !== rom_mem[5]) begin
      errors++; $display("FAIL if_rdata_hold: got %h want %h", bus1.if_rdata, rom_mem[5]);
    end
    do_txn(0, 0, 32'h0000_0018, 32'h0);
    checks++;
    if (bus1.dm_rdata !== ref_ram[64]) begin
      errors++; $display("FAIL dm_rdata_hold: got %h want %h", bus1.dm_rdata, ref_ram[64]);
    end
  endtask

  task automatic test_tie();
    bit last_dm, exp_first_dm, got_dm [2];
    int n;
    do_reset();
    last_dm = 1;
    for (int r = 0; r < 2; r++) begin
`ifdef MEM_BUS_ARB_RR_EN
      exp_first_dm = !last_dm;
`else
      exp_first_dm = 1;
`endif
      last_dm = !exp_first_dm;
      bus1.if_req = 1; bus1.if_addr = 32'h8 + 4 * r;
      bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 32'h800 + 4 * r;
      n = 0;
      for (int c = 0; c < 30 && n < 2; c++) begin
        @(posedge clk); #1;
        if (bus1.if_ack) begin
          got_dm[n] = 0; n++; bus1.if_req = 0;
          checks++;
          if (bus1.if_rdata !== rom_mem[2 + r]) begin
            errors++; $display("FAIL tie_if_rdata: got %h want %h", bus1.if_rdata, rom_mem[2+r]);
          end
        end else if (bus1.dm_ack) begin
          got_dm[n] = 1; n++; bus1.dm_req = 0;
          checks++;
          if (bus1.dm_rdata !== ref_ram[r]) begin
            errors++; $display("FAIL tie_dm_rdata: got %h want %h", bus1.dm_rdata, ref_ram[r]);
          end
        end
      end
      checks++;
      if (n !== 2) begin
        errors++; $display("FAIL tie_served round %0d: got %0d acks want 2", r, n);
        bus1.if_req = 0; bus1.dm_req = 0;
      end else begin
        checks++;
        if (got_dm[0] !== exp_first_dm || got_dm[1] !== !exp_first_dm) begin
          errors++;
          $display("FAIL tie_order round %0d: got dm_first=%0b want %0b", r, got_dm[0],
                   exp_first_dm);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    bus1.dm_req = 1; bus1.dm_we = 1; bus1.dm_addr = 32'h820; bus1.dm_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    checks++;
    if (bus1.ram_nce !== 1'b0) begin
      errors++; $display("FAIL midflight_strobe: got ram_nce=%b want 0", bus1.ram_nce);
    end
    @(posedge clk); #1;
    rst = 1; bus1.dm_req = 0;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({bus1.ram_nce, bus1.ram_we} !== 2'b10) begin
      errors++; $display("FAIL midflight_release: got nce/we=%b want 10",
                         {bus1.ram_nce, bus1.ram_we});
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus1.dm_ack || bus1.if_ack) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midflight_no_ack: got ack want none");
    end
    do_txn(1, 1, 32'h0000_0820, 32'h1234_5678);
    do_txn(1, 0, 32'h0000_0820, 32'h0);
  endtask

  task automatic test_wait_states();
    int w0, w7, l0, l7, lat;
    logic [31:0] d0, d7;
    w0 = 0; w7 = 0; l0 = 0; l7 = 0; lat = 1; d0 = 0; d7 = 0;
    bus0.if_req = 1; bus0.if_addr = 32'h8;
    bus7.if_req = 1; bus7.if_addr = 32'h8;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      lat++;
      if (!bus0.rom_nce && bus0.rom_re) w0++;
      if (!bus7.rom_nce && bus7.rom_re) w7++;
      if (bus0.if_ack && l0 == 0) begin l0 = lat; d0 = bus0.if_rdata; bus0.if_req = 0; end
      if (bus7.if_ack && l7 == 0) begin l7 = lat; d7 = bus7.if_rdata; bus7.if_req = 0; end
    end
    bus0.if_req = 0; bus7.if_req = 0;
    checks++;
    if (w0 !== 1) begin errors++; $display("FAIL ws0_width: got %0d want 1", w0); end
    checks++;
    if (l0 !== 3) begin errors++; $display("FAIL ws0_latency: got %0d want 3", l0); end
    checks++;
    if (d0 !== 32'hA5A5_0002) begin
      errors++; $display("FAIL ws0_rdata: got %h want a5a50002", d0);
    end
    checks++;
    if (w7 !== 8) begin errors++; $display("FAIL ws7_width: got %0d want 8", w7); end
    checks++;
    if (l7 !== 10) begin errors++; $display("FAIL ws7_latency: got %0d want 10", l7); end
    checks++;
    if (d7 !== 32'hA5A5_0002) begin
      errors++; $display("FAIL ws7_rdata: got %h want a5a50002", d7);
    end
  endtask

  task automatic test_random();
    logic [31:0] tmp, addr;
    int cls;
    for (int n = 0; n < 40; n++) begin
      tmp = $urandom;
      cls = $urandom_range(0, 4);
      case (cls)
        0:       addr = {21'd0, tmp[10:2], 2'b00};
        1, 4:    addr = {20'd0, 1'b1, tmp[10:2], 2'b00};
        2:       addr = {20'd0, tmp[11:2], (tmp[1:0] == 2'b00) ? 2'b01 : tmp[1:0]};
        default: addr = {tmp[31:12] | 20'h1, tmp[11:2], 2'b00};
      endcase
      do_txn(1'($urandom_range(0, 1)), (cls == 4) ? 1'b1 : 1'($urandom_range(0, 1)), addr,
             $urandom);
    end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 512; i++) begin
      rom_mem[i] = 32'h3C00_0000 ^ (i * 32'h0001_0203);
      ref_ram[i] = 32'hC0DE_0000 | i;
    end
    rom_mem[1] = 32'h0001_0A00;
    test_reset();
    test_directed();
    test_rdata_hold();
    test_tie();
    test_reset_midflight();
    test_wait_states();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
